trace_checker: RTL and testbench

Consumer end of the single-write commit trace stream (debug_wb_pc / debug_wb_rf_*). It compares each architectural register write against a golden trace entry supplied through a valid/ready stream from a trace loader, buffered in a small FIFO. The first divergence is latched with its expected and observed values, and the block flags pass when the final golden entry has matched. It sits in the SoC test wrapper beside the core's trace output.

---
 rtl/trace_checker.sv | 83 ++++++++
 tb/tb_trace_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// trace_checker: compares committed register writes against a golden trace stream
module trace_checker #(
  parameter int GOLD_DEPTH = 8,
  parameter int GOLD_PTR_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_wen,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_wnum,
  input  logic [31:0] gold_wdata,
  input  logic        gold_last,
  input  logic        start,
  output logic [1:0]  state,
  output logic [1:0]  err_code,
  output logic [31:0] err_pc,
  output logic [31:0] err_exp_wdata,
  output logic [31:0] err_got_wdata,
  output logic [31:0] match_count
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10, ERROR = 2'b11} state_t;
  state_t st;
  logic [69:0] ram [GOLD_DEPTH];
  logic [GOLD_PTR_W-1:0] rd_ptr, wr_ptr;
  logic [GOLD_PTR_W:0] count;
  logic [69:0] head;
  logic ev, push, pop, empty, pc_bad, data_bad;
  logic [1:0] fail_code;
  assign state = st;
  assign head = ram[rd_ptr];
  assign empty = count == '0;
  assign ev = (|debug_wb_rf_wen) && debug_wb_rf_wnum != 5'd0;
  // count never exceeds GOLD_DEPTH, so its MSB alone marks a full FIFO
  assign gold_ready = !reset && (st == IDLE || st == RUN) && !count[GOLD_PTR_W];
  assign push = gold_valid && gold_ready;
  assign pc_bad = head[69:38] != debug_wb_pc;
  assign data_bad = head[37:6] != debug_wb_rf_wdata || head[5:1] != debug_wb_rf_wnum;
  assign pop = st == RUN && ev && !empty && !pc_bad && !data_bad;
  // classify the current commit; PC mismatch outranks data mismatch, missing entry outranks both
  always_comb begin
    fail_code = 2'b00;
    if ((st == RUN || st == DONE) && ev)
      fail_code = (st == DONE || empty) ? 2'b11 : pc_bad ? 2'b01 : data_bad ? 2'b10 : 2'b00;
  end
  // golden storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) ram[wr_ptr] <= {gold_pc, gold_wdata, gold_wnum, gold_last};
  end
  // FIFO pointers, checker state and latched first failure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      err_code <= 2'b00;
      err_pc <= '0;
      err_exp_wdata <= '0;
      err_got_wdata <= '0;
      match_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        match_count <= match_count + 32'd1;
      end
      count <= count + {{GOLD_PTR_W{1'b0}}, push} - {{GOLD_PTR_W{1'b0}}, pop};
      if (fail_code != 2'b00) begin
        st <= ERROR;
        err_code <= fail_code;
        err_pc <= debug_wb_pc;
        err_exp_wdata <= fail_code == 2'b11 ? 32'd0 : head[37:6];
        err_got_wdata <= debug_wb_rf_wdata;
      end else if (st == IDLE && start) st <= RUN;
      else if (pop && head[0]) st <= DONE;
    end
  end
endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: randomized and directed checking of trace_checker against a queue model
module tb_trace_checker;
  logic clk = 0, reset = 1;
  logic [31:0] debug_wb_pc = 0, debug_wb_rf_wdata = 0, gold_pc = 0, gold_wdata = 0;
  logic [3:0] debug_wb_rf_wen = 0;
  logic [4:0] debug_wb_rf_wnum = 0, gold_wnum = 0;
  logic gold_valid = 0, gold_last = 0, start = 0, gold_ready;
  logic [1:0] state, err_code;
  logic [31:0] err_pc, err_exp_wdata, err_got_wdata, match_count;

  trace_checker dut (
    .clk(clk), .reset(reset), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc), .gold_wnum(gold_wnum),
    .gold_wdata(gold_wdata), .gold_last(gold_last), .start(start), .state(state),
    .err_code(err_code), .err_pc(err_pc), .err_exp_wdata(err_exp_wdata),
    .err_got_wdata(err_got_wdata), .match_count(match_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] wdata; logic [4:0] wnum; logic last;} ent_t;
  ent_t trace [64];
  int n = 0, gi = 0, ci = 0, checks = 0, failures = 0;
  bit cm = 0;

  ent_t q[$];
  int ms = 0, mcode = 0;
  logic [31:0] mpc = 0, mexp = 0, mgot = 0, mcnt = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, a, e, $time);
    end
  endtask

  function automatic bit mready();
    return !reset && ms < 2 && q.size() < 8;
  endfunction

  task automatic mfail(input int c, input logic [31:0] e);
    ms = 3; mcode = c; mpc = debug_wb_pc; mexp = e; mgot = debug_wb_rf_wdata;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete(); ms = 0; mcode = 0; mpc = 0; mexp = 0; mgot = 0; mcnt = 0;
    end else begin
      bit rdy, ev;
      rdy = mready();
      ev = debug_wb_rf_wen != 0 && debug_wb_rf_wnum != 0;
      if (ms == 0) begin
        if (start) ms = 1;
      end else if (ms == 1 && ev) begin
        if (q.size() == 0) mfail(3, 0);
        else if (q[0].pc != debug_wb_pc) mfail(1, q[0].wdata);
        else if (q[0].wnum != debug_wb_rf_wnum || q[0].wdata != debug_wb_rf_wdata) mfail(2, q[0].wdata);
        else begin
          mcnt++;
          if (q[0].last) ms = 2;
          void'(q.pop_front());
        end
      end else if (ms == 2 && ev) mfail(3, 0);
      if (gold_valid && rdy) q.push_back('{gold_pc, gold_wdata, gold_wnum, gold_last});
    end
  end

  always @(negedge clk) begin
    chk("state", state, ms);
    chk("err_code", err_code, mcode);
    chk("err_pc", err_pc, mpc);
    chk("err_exp_wdata", err_exp_wdata, mexp);
    chk("err_got_wdata", err_got_wdata, mgot);
    chk("match_count", match_count, mcnt);
    chk("gold_ready", gold_ready, mready());
  end

  task automatic tick();
    bit hs;
    @(negedge clk);
    hs = gold_valid && gold_ready;
    @(posedge clk);
    #2;
    if (hs) gi++;
    if (cm) ci++;
    cm = 0;
  endtask

  task automatic idle();
    tick();
    gold_valid = 0; start = 0; debug_wb_rf_wen = 0; debug_wb_rf_wnum = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    idle();
    reset = 0; gi = 0; ci = 0; cm = 0;
  endtask

  task automatic gen(input int len);
    n = len;
    for (int i = 0; i < len; i++)
      trace[i] = '{32'hBFC00000 + 32'(4 * i), $urandom, 5'($urandom_range(31, 1)), i == len - 1};
  endtask

  task automatic load3();
    n = 3;
    trace[0] = '{32'hBFC00000, 32'h11, 5'd1, 1'b0};
    trace[1] = '{32'hBFC00004, 32'h22, 5'd2, 1'b0};
    trace[2] = '{32'hBFC00008, 32'h33, 5'd3, 1'b1};
  endtask

  task automatic run(input int cyc, input int pg, input int pcm, input int pn,
                     input int start_at, input int bad_idx, input int bad_kind);
    for (int c = 0; c < cyc; c++) begin
      tick();
      gold_valid = gi < n && $urandom_range(99) < pg;
      if (gi < n) {gold_pc, gold_wdata, gold_wnum, gold_last} = {trace[gi].pc, trace[gi].wdata, trace[gi].wnum, trace[gi].last};
      start = c == start_at;
      debug_wb_rf_wen = 0;
      debug_wb_rf_wnum = 5'($urandom_range(31));
      debug_wb_pc = $urandom;
      debug_wb_rf_wdata = $urandom;
      if (c > start_at && ci < gi && $urandom_range(99) < pcm) begin
        debug_wb_pc = trace[ci].pc;
        debug_wb_rf_wnum = trace[ci].wnum;
        debug_wb_rf_wdata = trace[ci].wdata;
        debug_wb_rf_wen = 4'($urandom_range(15, 1));
        if (ci == bad_idx) begin
          if (bad_kind == 1) debug_wb_rf_wdata = trace[ci].wdata + 32'd1;
          if (bad_kind == 2) debug_wb_pc = trace[ci].pc ^ 32'h100;
          if (bad_kind == 3) debug_wb_rf_wnum = trace[ci].wnum == 5'd31 ? 5'd1 : trace[ci].wnum + 5'd1;
        end
        cm = 1;
      end else if ($urandom_range(99) < pn) begin
        if ($urandom_range(1) == 1) debug_wb_rf_wnum = 5'd0;
        else debug_wb_rf_wen = 0;
        if (debug_wb_rf_wnum == 5'd0) debug_wb_rf_wen = 4'($urandom_range(15, 1));
      end
    end
  endtask

  task automatic commit_once(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    tick();
    gold_valid = 0; start = 0;
    debug_wb_pc = pc; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd; debug_wb_rf_wen = 4'hF;
    idle();
  endtask

  task automatic pass3();
    load3();
    run(4, 100, 0, 0, -1, -1, 0);
    run(6, 100, 100, 0, 0, -1, 0);
    idle(); idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 0;
    pass3();
    chk("t1_state", state, 2); chk("t1_count", match_count, 3); chk("t1_code", err_code, 0);
    chk("t1_model_cnt", mcnt, 3);

    do_reset();
    load3();
    run(4, 100, 0, 0, -1, -1, 0);
    run(6, 100, 100, 0, 0, 2, 1);
    idle(); idle();
    chk("t2_state", state, 3); chk("t2_code", err_code, 2); chk("t2_pc", err_pc, 32'hBFC00008);
    chk("t2_exp", err_exp_wdata, 32'h33); chk("t2_got", err_got_wdata, 32'h34); chk("t2_count", match_count, 2);
    chk("t2_model_code", mcode, 2);

    do_reset();
    load3();
    run(30, 100, 50, 100, 0, -1, 0);
    idle(); idle();
    chk("t3_state", state, 2); chk("t3_count", match_count, 3);

    do_reset();
    gen(12);
    run(12, 100, 0, 0, -1, -1, 0);
    idle();
    chk("t4_accepts", gi, 8); chk("t4_ready_low", gold_ready, 0);
    run(24, 100, 100, 0, 0, -1, 0);
    idle(); idle();
    chk("t4_state", state, 2); chk("t4_count", match_count, 12); chk("t4_accepts_all", gi, 12);

    do_reset();
    n = 0;
    run(3, 0, 0, 0, 0, -1, 0);
    idle();
    commit_once(32'h1234, 5'd5, 32'hAB);
    chk("t5_state", state, 3); chk("t5_code", err_code, 3); chk("t5_pc", err_pc, 32'h1234);
    chk("t5_exp", err_exp_wdata, 0); chk("t5_got", err_got_wdata, 32'hAB);

    do_reset();
    pass3();
    commit_once(32'hBFC0000C, 5'd4, 32'h44);
    chk("t5b_state", state, 3); chk("t5b_code", err_code, 3); chk("t5b_count", match_count, 3);

    do_reset();
    gen(6);
    run(4, 100, 0, 0, 0, -1, 0);
    idle();
    chk("t6_queued", gi, 4); chk("t6_run", state, 1);
    reset = 1;
    #1;
    chk("t6_rst_state", state, 0); chk("t6_rst_count", match_count, 0); chk("t6_rst_ready", gold_ready, 0);
    @(posedge clk); #2;
    reset = 0; gi = 0; ci = 0; cm = 0;
    pass3();
    chk("t6_state", state, 2); chk("t6_count", match_count, 3);

    for (int it = 0; it < 25; it++) begin
      int k;
      do_reset();
      gen($urandom_range(40, 5));
      k = $urandom_range(5);
      run(4 * n + 40, $urandom_range(100, 30), $urandom_range(100, 30), 30,
          $urandom_range(10), $urandom_range(n - 1), k > 3 ? 0 : k);
      idle(); idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
